// File: rtl/scpad_pkg.sv
// ============================================================================
// scpad_pkg : shared types and defaults for the scratchpad bank arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package scpad_pkg;

  localparam int SCPAD_ARB_STARVE_MAX = 4;
  localparam int SCPAD_SRAM_LAT       = 2;
  localparam int SCPAD_TAG_W          = 6;

  typedef enum logic [0:0] {
    ACTIVE = 1'b0,
    DRAIN  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                   valid;
    logic [SCPAD_TAG_W-1:0] tag;
  } rd_lat_entry_t;

endpackage

`default_nettype wire

// File: rtl/scpad_bank_arb_if.sv
// ============================================================================
// scpad_bank_arb_if : request, SRAM, response and drain signals of one bank
// Rev 1.0
// ============================================================================
`default_nettype none

interface scpad_bank_arb_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128,
  parameter int TAG_W  = 6
);

  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [TAG_W-1:0]  rd_tag;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_urgent;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic              rsp_valid;
  logic [TAG_W-1:0]  rsp_tag;
  logic [DATA_W-1:0] rsp_data;
  logic              drain_req;
  logic              drain_done;
  logic [31:0]       perf_rd_grants;
  logic [31:0]       perf_wr_grants;
  logic [31:0]       perf_forced;
  logic [31:0]       perf_drain_cyc;

  // master side is the request queues plus the SRAM macro
  modport master (
    output rd_valid, rd_addr, rd_tag, wr_valid, wr_addr, wr_data, wr_urgent,
           sram_rdata, drain_req,
    input  rd_ready, wr_ready, sram_en, sram_we, sram_addr, sram_wdata,
           rsp_valid, rsp_tag, rsp_data, drain_done,
           perf_rd_grants, perf_wr_grants, perf_forced, perf_drain_cyc
  );

  modport slave (
    input  rd_valid, rd_addr, rd_tag, wr_valid, wr_addr, wr_data, wr_urgent,
           sram_rdata, drain_req,
    output rd_ready, wr_ready, sram_en, sram_we, sram_addr, sram_wdata,
           rsp_valid, rsp_tag, rsp_data, drain_done,
           perf_rd_grants, perf_wr_grants, perf_forced, perf_drain_cyc
  );

endinterface

`default_nettype wire

// File: rtl/scpad_rd_lat_pipe.sv
// ============================================================================
// scpad_rd_lat_pipe : valid+tag shift register spanning the SRAM read latency
// Rev 1.0
// ============================================================================
`default_nettype none

module scpad_rd_lat_pipe
  import scpad_pkg::*;
#(
  parameter int DEPTH = SCPAD_SRAM_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  rd_lat_entry_t in_entry,
  output rd_lat_entry_t out_entry,
  output logic          any_valid
);

  rd_lat_entry_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= in_entry;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage[i].valid;
  end

  assign out_entry = stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/scpad_bank_arb.sv
// ============================================================================
// scpad_bank_arb : read/write scheduler, read tracking and drain for one bank
// Optional counters: define SCPAD_ARB_PERF_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module scpad_bank_arb
  import scpad_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 128,
  parameter int TAG_W      = SCPAD_TAG_W,
  parameter int SRAM_LAT   = SCPAD_SRAM_LAT,
  parameter int STARVE_MAX = SCPAD_ARB_STARVE_MAX
) (
  input  logic           clk,
  input  logic           rst,
  scpad_bank_arb_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             grant_rd;
  logic             grant_wr;
  logic             grant_forced;
  rd_lat_entry_t    pipe_in;
  rd_lat_entry_t    pipe_out;
  logic             pipe_any;

  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

  // Grants are gated by rst so the bank is silent during the reset cycle.
  always_comb begin
    grant_rd     = 1'b0;
    grant_wr     = 1'b0;
    grant_forced = 1'b0;
    if (!rst && state == ACTIVE) begin
      if (bus.wr_valid && (bus.wr_urgent || starved)) begin
        grant_wr     = 1'b1;
        grant_forced = 1'b1;
      end else if (bus.rd_valid) begin
        grant_rd = 1'b1;
      end else if (bus.wr_valid) begin
        grant_wr = 1'b1;
      end
    end
  end

  assign bus.rd_ready   = grant_rd;
  assign bus.wr_ready   = grant_wr;
  assign bus.sram_en    = grant_rd | grant_wr;
  assign bus.sram_we    = grant_wr;
  assign bus.sram_addr  = grant_wr ? bus.wr_addr :
                          grant_rd ? bus.rd_addr : {ADDR_W{1'b0}};
  assign bus.sram_wdata = grant_wr ? bus.wr_data : {DATA_W{1'b0}};

  always_comb begin
    pipe_in       = '0;
    pipe_in.valid = grant_rd;
    if (grant_rd) pipe_in.tag = SCPAD_TAG_W'(bus.rd_tag);
  end

  scpad_rd_lat_pipe #(
    .DEPTH (SRAM_LAT)
  ) u_rd_lat_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_entry  (pipe_in),
    .out_entry (pipe_out),
    .any_valid (pipe_any)
  );

  assign bus.rsp_valid = pipe_out.valid;
  assign bus.rsp_tag   = pipe_out.valid ? TAG_W'(pipe_out.tag) : {TAG_W{1'b0}};
  assign bus.rsp_data  = pipe_out.valid ? bus.sram_rdata : {DATA_W{1'b0}};

  // drain_done follows the state register and pipe occupancy; a falling
  // drain_req withdraws it immediately, ahead of the return to ACTIVE.
  assign bus.drain_done = (state == DRAIN) && bus.drain_req && !pipe_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACTIVE;
      starve_cnt <= '0;
    end else begin
      case (state)
        ACTIVE:  if (bus.drain_req)  state <= DRAIN;
        DRAIN:   if (!bus.drain_req) state <= ACTIVE;
        default: state <= ACTIVE;
      endcase
      if (!bus.wr_valid || grant_wr) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SCPAD_ARB_PERF_EN
  logic [31:0] cnt_rd;
  logic [31:0] cnt_wr;
  logic [31:0] cnt_forced;
  logic [31:0] cnt_drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_rd     <= '0;
      cnt_wr     <= '0;
      cnt_forced <= '0;
      cnt_drain  <= '0;
    end else begin
      if (grant_rd)       cnt_rd     <= cnt_rd + 32'd1;
      if (grant_wr)       cnt_wr     <= cnt_wr + 32'd1;
      if (grant_forced)   cnt_forced <= cnt_forced + 32'd1;
      if (state == DRAIN) cnt_drain  <= cnt_drain + 32'd1;
    end
  end

  assign bus.perf_rd_grants = cnt_rd;
  assign bus.perf_wr_grants = cnt_wr;
  assign bus.perf_forced    = cnt_forced;
  assign bus.perf_drain_cyc = cnt_drain;
`else
  logic unused_forced;
  assign unused_forced      = grant_forced;
  assign bus.perf_rd_grants = 32'd0;
  assign bus.perf_wr_grants = 32'd0;
  assign bus.perf_forced    = 32'd0;
  assign bus.perf_drain_cyc = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_scpad_bank_arb.sv
// ============================================================================
// tb_scpad_bank_arb : directed vector bench with a behavioural latency-2 SRAM
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_scpad_bank_arb;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 128;
  localparam int TAG_W  = 6;
`ifdef SCPAD_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scpad_bank_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  scpad_bank_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .SRAM_LAT(2), .STARVE_MAX(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM model: unwritten words read back as a fixed address pattern
  logic [DATA_W-1:0] mem [1024];
  logic [1023:0]     written;
  logic [DATA_W-1:0] rd_d1, rd_d2;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return {64'hC0DE_0000_0000_0000, 54'h0, a};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      written <= '0;
    end else if (bus.sram_en && bus.sram_we) begin
      mem[bus.sram_addr]     <= bus.sram_wdata;
      written[bus.sram_addr] <= 1'b1;
    end
    rd_d1 <= written[bus.sram_addr] ? mem[bus.sram_addr] : pat(bus.sram_addr);
    rd_d2 <= rd_d1;
  end
  assign bus.sram_rdata = rd_d2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic rv, input logic [9:0] ra, input logic [5:0] rt,
                       input logic wv, input logic [9:0] wa, input logic [127:0] wd,
                       input logic urg, input logic dr);
    @(negedge clk);
    bus.rd_valid  = rv;
    bus.rd_addr   = ra;
    bus.rd_tag    = rt;
    bus.wr_valid  = wv;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.wr_urgent = urg;
    bus.drain_req = dr;
    #1;
  endtask

  task automatic idle(input logic dr);
    drive(1'b0, 10'h0, 6'h0, 1'b0, 10'h0, 128'h0, 1'b0, dr);
  endtask

  typedef struct {
    logic       rv;
    logic       wv;
    logic       urg;
    logic [9:0] ra;
    logic [9:0] wa;
    logic       exp_rr;
    logic       exp_wr;
  } vec_t;

  vec_t tv [21];

  initial begin
    logic [127:0] wd;
    logic [9:0]   exp_addr;

    // Contention and priority sequence, applied on consecutive cycles
    for (int i = 0; i < 10; i++)
      tv[i] = '{1'b1, 1'b1, 1'b0, 10'(256 + i), 10'h200, !(i == 4 || i == 9), (i == 4 || i == 9)};
    tv[10] = '{1'b1, 1'b1, 1'b1, 10'h120, 10'h210, 1'b0, 1'b1};
    tv[11] = '{1'b1, 1'b1, 1'b0, 10'h121, 10'h211, 1'b1, 1'b0};
    tv[12] = '{1'b0, 1'b1, 1'b0, 10'h122, 10'h212, 1'b0, 1'b1};
    tv[13] = '{1'b0, 1'b0, 1'b0, 10'h123, 10'h213, 1'b0, 1'b0};
    tv[14] = '{1'b1, 1'b1, 1'b0, 10'h124, 10'h214, 1'b1, 1'b0};
    tv[15] = '{1'b0, 1'b0, 1'b0, 10'h125, 10'h215, 1'b0, 1'b0};
    for (int i = 16; i < 20; i++)
      tv[i] = '{1'b1, 1'b1, 1'b0, 10'(288 + i), 10'h220, 1'b1, 1'b0};
    tv[20] = '{1'b1, 1'b1, 1'b0, 10'h135, 10'h221, 1'b0, 1'b1};

    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    drive(1'b1, 10'h3FF, 6'h3F, 1'b1, 10'h155, {4{32'hFFFF_FFFF}}, 1'b1, 1'b0);
    chk("rst_rd_ready", bus.rd_ready, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_sram_en", bus.sram_en, 0);
    chk("rst_sram_we", bus.sram_we, 0);
    chk("rst_sram_addr", bus.sram_addr, 0);
    chk("rst_sram_wdata", bus.sram_wdata, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_tag", bus.rsp_tag, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_drain_done", bus.drain_done, 0);
    chk("rst_perf_rd", bus.perf_rd_grants, 0);
    chk("rst_perf_forced", bus.perf_forced, 0);
    idle(1'b0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      wd = {8{16'hA500 + 16'(i)}};
      drive(tv[i].rv, tv[i].ra, 6'(i), tv[i].wv, tv[i].wa, wd, tv[i].urg, 1'b0);
      exp_addr = tv[i].exp_wr ? tv[i].wa : (tv[i].exp_rr ? tv[i].ra : 10'h0);
      chk($sformatf("vec%0d_rd_ready", i), bus.rd_ready, tv[i].exp_rr);
      chk($sformatf("vec%0d_wr_ready", i), bus.wr_ready, tv[i].exp_wr);
      chk($sformatf("vec%0d_sram_en", i), bus.sram_en, tv[i].exp_rr | tv[i].exp_wr);
      chk($sformatf("vec%0d_sram_we", i), bus.sram_we, tv[i].exp_wr);
      chk($sformatf("vec%0d_sram_addr", i), bus.sram_addr, exp_addr);
      chk($sformatf("vec%0d_sram_wdata", i), bus.sram_wdata, tv[i].exp_wr ? wd : 128'h0);
    end
    idle(1'b0);
    chk("perf_rd_grants", bus.perf_rd_grants, PERF ? 14 : 0);
    chk("perf_wr_grants", bus.perf_wr_grants, PERF ? 5 : 0);
    chk("perf_forced", bus.perf_forced, PERF ? 4 : 0);

    // Single read, response two cycles later
    idle(1'b0);
    idle(1'b0);
    drive(1'b1, 10'h010, 6'd5, 1'b0, 10'h0, 128'h0, 1'b0, 1'b0);
    chk("rd1_rd_ready", bus.rd_ready, 1);
    chk("rd1_sram_en", bus.sram_en, 1);
    chk("rd1_sram_we", bus.sram_we, 0);
    chk("rd1_sram_addr", bus.sram_addr, 10'h010);
    idle(1'b0);
    chk("rd1_rsp_early", bus.rsp_valid, 0);
    idle(1'b0);
    chk("rd1_rsp_valid", bus.rsp_valid, 1);
    chk("rd1_rsp_tag", bus.rsp_tag, 5);
    chk("rd1_rsp_data", bus.rsp_data, pat(10'h010));
    idle(1'b0);
    chk("rd1_rsp_late", bus.rsp_valid, 0);

    // Write then read of the same word
    drive(1'b0, 10'h0, 6'h0, 1'b1, 10'h007, {16{8'hAA}}, 1'b0, 1'b0);
    chk("raw_wr_ready", bus.wr_ready, 1);
    drive(1'b1, 10'h007, 6'd9, 1'b0, 10'h0, 128'h0, 1'b0, 1'b0);
    chk("raw_rd_ready", bus.rd_ready, 1);
    idle(1'b0);
    chk("raw_rsp_early", bus.rsp_valid, 0);
    idle(1'b0);
    chk("raw_rsp_valid", bus.rsp_valid, 1);
    chk("raw_rsp_tag", bus.rsp_tag, 9);
    chk("raw_rsp_data", bus.rsp_data, {16{8'hAA}});

    // Drain with two reads in flight
    idle(1'b0);
    idle(1'b0);
    drive(1'b1, 10'h030, 6'd1, 1'b0, 10'h0, 128'h0, 1'b0, 1'b0);
    chk("drn_grant0", bus.rd_ready, 1);
    drive(1'b1, 10'h031, 6'd2, 1'b0, 10'h0, 128'h0, 1'b0, 1'b1);
    chk("drn_grant1", bus.rd_ready, 1);
    drive(1'b1, 10'h032, 6'd3, 1'b1, 10'h040, 128'h1, 1'b0, 1'b1);
    chk("drn_c2_rd_ready", bus.rd_ready, 0);
    chk("drn_c2_wr_ready", bus.wr_ready, 0);
    chk("drn_c2_rsp_valid", bus.rsp_valid, 1);
    chk("drn_c2_rsp_tag", bus.rsp_tag, 1);
    chk("drn_c2_done", bus.drain_done, 0);
    drive(1'b1, 10'h032, 6'd3, 1'b1, 10'h040, 128'h1, 1'b1, 1'b1);
    chk("drn_c3_sram_en", bus.sram_en, 0);
    chk("drn_c3_rsp_valid", bus.rsp_valid, 1);
    chk("drn_c3_rsp_tag", bus.rsp_tag, 2);
    chk("drn_c3_done", bus.drain_done, 0);
    drive(1'b1, 10'h032, 6'd3, 1'b1, 10'h040, 128'h1, 1'b0, 1'b1);
    chk("drn_c4_done", bus.drain_done, 1);
    chk("drn_c4_rsp_valid", bus.rsp_valid, 0);
    chk("drn_c4_sram_en", bus.sram_en, 0);
    drive(1'b1, 10'h032, 6'd3, 1'b1, 10'h040, 128'h1, 1'b0, 1'b1);
    chk("drn_c5_done", bus.drain_done, 1);
    idle(1'b0);
    drive(1'b1, 10'h033, 6'd4, 1'b0, 10'h0, 128'h0, 1'b0, 1'b0);
    chk("drn_exit_done", bus.drain_done, 0);
    chk("drn_exit_rd_ready", bus.rd_ready, 1);
    chk("perf_drain_cyc", bus.perf_drain_cyc, PERF ? 5 : 0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    // Reset with a read in flight: its response must never appear
    drive(1'b1, 10'h050, 6'h3F, 1'b0, 10'h0, 128'h0, 1'b0, 1'b0);
    chk("rmf_grant", bus.rd_ready, 1);
    drive(1'b1, 10'h051, 6'h3E, 1'b1, 10'h052, 128'h5, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rmf_rst_rd_ready", bus.rd_ready, 0);
    chk("rmf_rst_wr_ready", bus.wr_ready, 0);
    chk("rmf_rst_sram_en", bus.sram_en, 0);
    idle(1'b0);
    rst = 1'b0;
    #1;
    chk("rmf_c2_rsp_valid", bus.rsp_valid, 0);
    chk("rmf_c2_rsp_tag", bus.rsp_tag, 0);
    chk("rmf_c2_rsp_data", bus.rsp_data, 0);
    chk("rmf_c2_sram_addr", bus.sram_addr, 0);
    chk("rmf_c2_drain_done", bus.drain_done, 0);
    chk("rmf_c2_perf_rd", bus.perf_rd_grants, 0);
    idle(1'b0);
    chk("rmf_c3_rsp_valid", bus.rsp_valid, 0);
    idle(1'b0);
    chk("rmf_c4_rsp_valid", bus.rsp_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scpad_bank_arb.md
Name: scpad_bank_arb

Overview:
- Per-bank access scheduler for one scratchpad SRAM bank.
- Arbitrates each cycle between the head of the bank's read request queue and the head of its write request queue, and drives the single-ported SRAM.
- Tracks in-flight reads across the fixed SRAM latency and returns tagged read responses.
- Provides a quiesce (drain) handshake used before bank reconfiguration or mode switches.

Parameters:
- ADDR_W, 10, bank word address width
- DATA_W, 128, SRAM word width
- TAG_W, 6, read request tag width returned with response
- SRAM_LAT, 2, cycles from SRAM enable to valid sram_rdata (>=1)
- STARVE_MAX, 4, consecutive denied-write cycles before write is forced to win

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_valid  in  1  read request present
- rd_ready  out  1  read request accepted this cycle
- rd_addr  in  ADDR_W  read address
- rd_tag  in  TAG_W  read tag
- wr_valid  in  1  write request present
- wr_ready  out  1  write request accepted this cycle
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_urgent  in  1  write queue at high watermark; write priority
- sram_en  out  1  SRAM access enable
- sram_we  out  1  1=write, 0=read
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid SRAM_LAT cycles after read enable
- rsp_valid  out  1  read response valid (no backpressure)
- rsp_tag  out  TAG_W  response tag
- rsp_data  out  DATA_W  response data
- drain_req  in  1  level; stop accepting, empty pipeline
- drain_done  out  1  level; bank idle, no reads in flight
- perf_rd_grants, perf_wr_grants, perf_forced, perf_drain_cyc  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset (clk edge with rst=1): FSM=ACTIVE, starve_cnt=0, latency pipe cleared.
- Reset values: rd_ready=0, wr_ready=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0, rsp_valid=0, rsp_tag=0, rsp_data=0, drain_done=0.
- Reset mid-operation drops in-flight reads: no response is issued for them.
- Grant is combinational, at most one per cycle. The accepted request drives sram_* in the same cycle: sram_en = rd_ready|wr_ready.
- Priority in ACTIVE, first match wins:
  1. wr_valid & (wr_urgent | starve_cnt==STARVE_MAX) -> write (forced)
  2. rd_valid -> read
  3. wr_valid -> write
- starve_cnt:
  - increments, saturating at STARVE_MAX, when wr_valid=1 and no write is granted.
  - clears on any write grant or when wr_valid=0.
- Read response: read granted in cycle N gives rsp_valid=1 in cycle N+SRAM_LAT, with rsp_tag=rd_tag captured at N and rsp_data=sram_rdata.
  - The latency pipe is a SRAM_LAT-deep valid+tag shift register.
  - Back-to-back reads produce back-to-back responses.
- Ordering: write at N then read of the same address at N+1 returns the new data (SRAM ordering, no bypass needed).
- FSM states:
  - ACTIVE -> DRAIN on drain_req=1.
  - DRAIN: rd_ready=wr_ready=0. drain_done=1 when the latency pipe holds no valid entries (registered, same cycle the pipe empties).
  - DRAIN -> ACTIVE when drain_req=0; drain_done drops to 0 in that cycle.
- drain_req during a grant cycle: the grant in that cycle completes. drain_req raised in cycle N blocks grants from N+1.
- drain_req with empty pipe: drain_done=1 on the next cycle.

Optional Feature:
- SCPAD_ARB_PERF_EN defined: four 32-bit wrapping counters, cleared by rst.
  - perf_rd_grants: +1 per read grant.
  - perf_wr_grants: +1 per write grant.
  - perf_forced: +1 per priority-1 write grant.
  - perf_drain_cyc: +1 per cycle in DRAIN.
- Undefined: perf_* ports tied to 0; no counter flops.

Decomposition:
- scpad_pkg holds:
  - arb_state_t enum {ACTIVE, DRAIN}.
  - rd_lat_entry_t struct {valid, tag}.
  - Constants SCPAD_ARB_STARVE_MAX=4 and SCPAD_SRAM_LAT=2, used as parameter defaults.
- Sub-module scpad_rd_lat_pipe: parameterised shift register (depth SRAM_LAT, entry rd_lat_entry_t), with an "any valid" output used for drain_done.

Test Plan:
- Single read: rd_valid=1, addr=0x010, tag=5 at cycle 3 -> rd_ready=1, sram_en=1, sram_we=0 at cycle 3; rsp_valid=1, tag=5 at cycle 5 (SRAM_LAT=2).
- Contention: rd_valid and wr_valid both held high 10 cycles, wr_urgent=0 -> reads granted cycles 0-3, write forced at cycle 4, reads 5-8, write at 9; perf_forced=2.
- Urgent write: rd_valid=wr_valid=wr_urgent=1 -> write granted the same cycle; starve_cnt=0 next cycle.
- RAW ordering: write 0xAA.. to addr 7 at cycle N, read addr 7 at N+1 -> rsp_data=0xAA.. at N+3.
- Drain: 2 reads granted at cycles 0-1, drain_req=1 at cycle 1 -> no grants from cycle 2; responses at cycles 2-3; drain_done=1 from cycle 4 until drain_req falls.
- Reset mid-flight: read granted at cycle 0, rst=1 at cycle 1 -> rsp_valid stays 0 through cycle 4; all outputs at reset values.
